// File: rtl/pipelined_cs_subtractor.sv
// pipelined_cs_subtractor
//
// Two-stage pipelined carry-select subtractor: diff = (a - b - bin) mod 2^WIDTH.
// Stage 1 registers the low-half difference and its borrow, together with two
// speculative high halves: d0 assumes no borrow into the high half and d1 assumes
// a borrow. Stage 2 picks one high candidate using the registered low-half borrow.
// Valid/ready handshakes on both sides allow one operation per cycle.
//
// Parameters:
//   WIDTH      operand width; must be even and >= 4 (split point H = WIDTH/2)
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present
//   in_ready   block can accept operands this cycle
//   a, b, bin  minuend, subtrahend, borrow in
//   out_valid  result present
//   out_ready  consumer accepts result this cycle
//   diff       (a - b - bin) mod 2^WIDTH
//   bout       unsigned borrow out (a < b + bin)
//   ovf        signed overflow of the exact a - b - bin

module pipelined_cs_subtractor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned H = WIDTH / 2;

    // Stage 1 state
    logic         s1_valid_q, s1_valid_d;
    logic [H-1:0] s1_lo_q;
    logic         s1_lo_borrow_q;
    logic [H-1:0] s1_hi0_q, s1_hi1_q;
    logic         s1_bout0_q, s1_bout1_q;
    logic         s1_ovf0_q, s1_ovf1_q;

    // Stage 2 state
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q, ovf_q;

    // Extended by one bit so the MSB of each result is the borrow out.
    logic [H:0] lo_ext, hi0_ext, hi1_ext;
    logic       ovf0, ovf1;

    logic s1_load, s2_load;

    always_comb begin
        lo_ext  = {1'b0, a[H-1:0]} - {1'b0, b[H-1:0]} - {{H{1'b0}}, bin};
        hi0_ext = {1'b0, a[WIDTH-1:H]} - {1'b0, b[WIDTH-1:H]};
        hi1_ext = hi0_ext - {{H{1'b0}}, 1'b1};
        // Signed overflow of a - b - c: operand signs differ and the result sign
        // differs from the minuend's sign.
        ovf0 = (a[WIDTH-1] ^ b[WIDTH-1]) & (hi0_ext[H-1] ^ a[WIDTH-1]);
        ovf1 = (a[WIDTH-1] ^ b[WIDTH-1]) & (hi1_ext[H-1] ^ a[WIDTH-1]);
    end

    // Handshake: stage 2 frees up when empty or being popped; stage 1 can take new
    // operands when empty or when its contents advance into stage 2 this cycle.
    always_comb begin
        s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready = !s1_valid_q || s2_load;
        s1_load  = in_valid && in_ready;

        s1_valid_d = s1_valid_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_lo_q        <= '0;
            s1_lo_borrow_q <= 1'b0;
            s1_hi0_q       <= '0;
            s1_hi1_q       <= '0;
            s1_bout0_q     <= 1'b0;
            s1_bout1_q     <= 1'b0;
            s1_ovf0_q      <= 1'b0;
            s1_ovf1_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                s1_lo_q        <= lo_ext[H-1:0];
                s1_lo_borrow_q <= lo_ext[H];
                s1_hi0_q       <= hi0_ext[H-1:0];
                s1_hi1_q       <= hi1_ext[H-1:0];
                s1_bout0_q     <= hi0_ext[H];
                s1_bout1_q     <= hi1_ext[H];
                s1_ovf0_q      <= ovf0;
                s1_ovf1_q      <= ovf1;
            end
        end
    end

    // Selection uses only the low-half borrow; bin was already folded into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                if (s1_lo_borrow_q) begin
                    diff_q <= {s1_hi1_q, s1_lo_q};
                    bout_q <= s1_bout1_q;
                    ovf_q  <= s1_ovf1_q;
                end else begin
                    diff_q <= {s1_hi0_q, s1_lo_q};
                    bout_q <= s1_bout0_q;
                    ovf_q  <= s1_ovf0_q;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cs_subtractor.sv
// Self-checking bench for pipelined_cs_subtractor (WIDTH = 32). Expected results
// come from an exact 64-bit reference model and are queued on accept, then
// compared against the output whenever out_valid is high.

module tb_pipelined_cs_subtractor;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;

    res_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_in     = 0;
    int   n_out    = 0;
    logic last_acc;
    logic last_ir;

    pipelined_cs_subtractor #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [31:0] aa, input logic [31:0] bb,
                                   input logic bi);
        res_t        r;
        logic [32:0] full;
        longint      s;
        full = {1'b0, aa} - {1'b0, bb} - {32'd0, bi};
        s    = longint'($signed(aa)) - longint'($signed(bb)) - longint'(bi);
        r.d  = full[31:0];
        r.bo = full[32];
        r.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, settle, check the output
    // against the scoreboard head, and record any accept at the coming edge.
    task automatic step(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                        input logic bi, input logic rdy);
        res_t e;
        @(negedge clk);
        in_valid  = v;
        a         = aa;
        b         = bb;
        bin       = bi;
        out_ready = rdy;
        #1;
        last_ir  = in_ready;
        last_acc = v && in_ready;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                e = sb[0];
                chk("diff", {32'd0, diff}, {32'd0, e.d});
                chk("bout", {63'd0, bout}, {63'd0, e.bo});
                chk("ovf",  {63'd0, ovf},  {63'd0, e.ov});
                if (rdy) begin
                    void'(sb.pop_front());
                    n_out++;
                end
            end
        end
        if (last_acc) begin
            sb.push_back(model(aa, bb, bi));
            n_in++;
        end
    endtask

    // Single operation into an empty pipe; checks accept and two-edge latency.
    task automatic run_vec(input logic [31:0] aa, input logic [31:0] bb, input logic bi);
        step(1'b1, aa, bb, bi, 1'b1);
        chk("vec_accept", {63'd0, last_acc}, 64'd1);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("vec_lat_early", {63'd0, out_valid}, 64'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("vec_lat_valid", {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        logic [31:0] bpa [4];
        logic [31:0] bpb [4];
        logic [31:0] ra, rb;
        logic [31:0] edge_vals [6];
        int          idx;
        int          c;

        bpa = '{32'h0000_0010, 32'h0001_0000, 32'h8000_0000, 32'h1234_5678};
        bpb = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_5679};
        edge_vals = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                      32'h0000_FFFF, 32'h0001_0000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_diff", {32'd0, diff}, 64'd0);
        chk("rst_bout", {63'd0, bout}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed vectors
        run_vec(32'd5, 32'd3, 1'b0);
        run_vec(32'd0, 32'd0, 1'b1);
        run_vec(32'h0001_0000, 32'd1, 1'b0);
        run_vec(32'h8000_0000, 32'd1, 1'b0);
        run_vec(32'h8000_0000, 32'd0, 1'b1);
        run_vec(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Backpressure: out_ready low for 3 cycles while offering 4 operations.
        idx = 0;
        c   = 0;
        while (idx < 4 && c < 20) begin
            step(1'b1, bpa[idx], bpb[idx], 1'b0, c >= 3);
            if (c == 2) chk("full_in_ready", {63'd0, last_ir}, 64'd0);
            if (last_acc) idx++;
            c++;
        end
        chk("bp_all_accepted", 64'(idx), 64'd4);
        c = 0;
        while (sb.size() > 0 && c < 10) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            chk("bp_stream_valid", {63'd0, out_valid}, 64'd1);
            c++;
        end
        chk("bp_drained", 64'(sb.size()), 64'd0);

        // Reset with two operations in flight.
        step(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_diff", {32'd0, diff}, 64'd0);
        chk("midrst_bout", {63'd0, bout}, 64'd0);
        chk("midrst_ovf", {63'd0, ovf}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            chk("no_stale", {63'd0, out_valid}, 64'd0);
        end

        // Random streams
        n_in  = 0;
        n_out = 0;
        c     = 0;
        while (n_in < 10000 && c < 60000) begin
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 3))
                1: rb[15:0] = ra[15:0];
                2: begin
                    ra = edge_vals[$urandom_range(0, 5)];
                    rb = edge_vals[$urandom_range(0, 5)];
                end
                default: ;
            endcase
            step($urandom_range(0, 9) < 7, ra, rb, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 6);
            c++;
        end
        chk("rand_in_count", 64'(n_in), 64'd10000);
        c = 0;
        while (sb.size() > 0 && c < 100) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            c++;
        end
        chk("rand_drained", 64'(sb.size()), 64'd0);
        chk("rand_in_eq_out", 64'(n_out), 64'(n_in));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
